// File: rtl/gates_pipe.sv
// Two-stage valid/ready pipeline computing vz = (va OP vb) | ~(vc & vd).
// Also provides reduction flags and a saturating count of output transfers.
module gates_pipe #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     va,
  input  logic [W-1:0]     vb,
  input  logic [W-1:0]     vc,
  input  logic [W-1:0]     vd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     vy,
  output logic [W-1:0]     vz,
  output logic             y_all,
  output logic             y_any,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         s1_v;
  logic [W-1:0] s1_ab;
  logic [W-1:0] s1_ncd;
  logic [W-1:0] ab_c;
  logic [W-1:0] ncd_c;
  logic [W-1:0] s2_vz_c;
  logic         s2_load_c;
  logic         s1_load_c;
  logic         accept_c;
  logic         xfer_c;

  // Operand stage logic
  always_comb begin
    ab_c = '0;
    unique case (op)
      2'b00:   ab_c = va & vb;
      2'b01:   ab_c = va | vb;
      2'b10:   ab_c = va ^ vb;
      default: ab_c = ~(va & vb);
    endcase
    ncd_c   = ~(vc & vd);
    s2_vz_c = s1_ab | s1_ncd;
  end

  // Advance and handshake control; in_ready is the only path from out_ready
  always_comb begin
    s2_load_c = s1_v & (~out_valid | out_ready);
    s1_load_c = ~s1_v | s2_load_c;
    in_ready  = ~rst & s1_load_c;
    accept_c  = in_valid & in_ready;
    xfer_c    = out_valid & out_ready;
  end

  // Stage 1: captures ab and ncd of the accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_ab  <= '0;
      s1_ncd <= '0;
    end else if (s1_load_c) begin
      s1_v <= accept_c;
      if (accept_c) begin
        s1_ab  <= ab_c;
        s1_ncd <= ncd_c;
      end
    end
  end

  // Stage 2: result registers, held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      vy        <= '0;
      vz        <= '0;
      y_all     <= 1'b0;
      y_any     <= 1'b0;
    end else if (s2_load_c) begin
      out_valid <= 1'b1;
      vy        <= s1_ab;
      vz        <= s2_vz_c;
      y_all     <= &s2_vz_c;
      y_any     <= |s2_vz_c;
    end else if (xfer_c) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating transfer counter; clear wins over a simultaneous transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (cnt_clr) begin
      txn_cnt <= '0;
    end else if (xfer_c && (txn_cnt != CNT_MAX)) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule
